// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply/multiply-accumulate sequencer driving the shared ALU adder.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
`ifndef ALU_ADD_FUNCTION
`define ALU_ADD_FUNCTION 3'b000
`endif

module alu_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mla,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_p, r_m, r_q, r_result;
  logic [WIDTH-1:0] w_p_nxt, w_m_nxt, w_q_nxt, w_result_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             w_early;

`ifdef MUL_EARLY_TERM_EN
  assign w_early = (r_q == '0);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_p_nxt      = r_p;
    w_m_nxt      = r_m;
    w_q_nxt      = r_q;
    w_cnt_nxt    = r_cnt;
    w_carry_nxt  = r_carry;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_p_nxt     = mla ? acc : '0;
          w_m_nxt     = op_a;
          w_q_nxt     = op_b;
          w_cnt_nxt   = '0;
          w_carry_nxt = 1'b0;
          w_state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        if (w_early) begin
          w_state_nxt  = S_DONE;
          w_result_nxt = r_p;
        end else begin
          if (r_q[0]) begin
            w_p_nxt     = alu_out;
            w_carry_nxt = r_carry | alu_cout;
          end
          w_m_nxt   = r_m << 1;
          w_q_nxt   = r_q >> 1;
          w_cnt_nxt = r_cnt + 1'b1;
          // result captures the post-update P so it is valid throughout DONE
          if (r_cnt == LAST_CNT) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = r_q[0] ? alu_out : r_p;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_p      <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_p      <= w_p_nxt;
      r_m      <= w_m_nxt;
      r_q      <= w_q_nxt;
      r_cnt    <= w_cnt_nxt;
      r_carry  <= w_carry_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign alu_sel  = busy;
  assign result   = r_result;
  assign carry    = r_carry;
  assign alu_a    = r_p;
  assign alu_b    = r_m;
  assign alu_func = `ALU_ADD_FUNCTION;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed + random bench for alu_mul_seq with a behavioural 32-bit ALU adder attached.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mla = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, acc = '0;
  logic        busy, done, carry, alu_sel, alu_cout;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [2:0]  alu_func;
  logic [32:0] alu_sum;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mla(mla),
    .op_a(op_a), .op_b(op_b), .acc(acc),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // ALU: only the add function (code 0) is modelled
  assign alu_sum  = (alu_func == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 33'd0;
  assign alu_out  = alu_sum[31:0];
  assign alu_cout = alu_sum[32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int m = -1;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    if (m < 0) return 1;
    return (m + 2 > 32) ? 32 : m + 2;
`else
    return 32;
`endif
  endfunction

  function automatic logic exp_carry(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] ac, input logic ml);
    logic [32:0] s;
    logic [31:0] p = ml ? ac : 32'd0;
    logic [31:0] m = a;
    logic        c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        s = {1'b0, p} + {1'b0, m};
        p = s[31:0];
        c = c | s[32];
      end
      m = m << 1;
    end
    return c;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ac,
                        input logic ml, input bit inject, input string tag);
    logic [31:0] exp_r;
    int lat = 0;
    int busy_low = 0;
    bit seen = 0;
    exp_r = a * b + (ml ? ac : 32'd0);
    @(negedge clk);
    op_a = a; op_b = b; acc = ac; mla = ml; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; acc = $urandom; mla = $urandom_range(0, 1);
    for (int n = 1; n <= 40 && !seen; n++) begin
      if (inject && n == 5) begin
        op_a = 32'h7; op_b = 32'h3; mla = 1'b0; start = 1'b1;
      end
      if (inject && n == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        lat = n;
      end else if (!busy || !alu_sel) busy_low++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({tag, "_result"}, 64'(result), 64'(exp_r));
    chk({tag, "_carry"}, 64'(carry), 64'(exp_carry(a, b, ac, ml)));
    chk({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_after"}, {62'd0, done, busy}, 64'd0);
    chk({tag, "_held"}, 64'(result), 64'(exp_r));
  endtask

  initial begin
    int dcount;
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset", {29'd0, busy, done, alu_sel, carry, result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {29'd0, busy, done, alu_sel, carry, result}, 64'd0);
    end
    chk("alu_func", 64'(alu_func), 64'd0);

    run_op(32'h0000_1234, 32'h0000_0010, 32'h0, 1'b0, 0, "mul");
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 32'h5, 1'b1, 0, "mla_wrap");
    run_op(32'h0000_1234, 32'h0000_0010, 32'h0, 1'b0, 1, "busy_rej");
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("no_second_done", 64'(dcount), 64'd0);
    run_op(32'h1234_5678, 32'h0000_0000, 32'h0000_0009, 1'b1, 0, "b_zero");
    run_op(32'hDEAD_BEEF, 32'h0000_0001, 32'h0, 1'b0, 0, "b_one");
    run_op(32'h8000_0001, 32'h8000_0000, 32'h0, 1'b0, 0, "b_msb");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "all_ones");

    // abort after 10 iterations
    @(negedge clk);
    op_a = 32'h0000_0003; op_b = 32'hFFFF_FFFF; acc = 32'h0; mla = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset", {30'd0, busy, alu_sel, result}, 64'd0);
    chk("mid_reset_done", {62'd0, done, carry}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("no_done_after_reset", 64'(dcount), 64'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b, c;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 32);
      c = $urandom;
      run_op(a, b, c, 1'($urandom_range(0, 1)), 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
